// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream merger with a per-owner burst allowance.
// Output beat is fully registered and tagged with its source index.
module axis_rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned SRC_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [SRC_W-1:0]                m_tsrc
);

  localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [SRC_W-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [SRC_W-1:0]      m_tsrc_q, m_tsrc_d;

  logic [SRC_W-1:0]      sel_c;
  logic                  any_valid_c;
  logic                  load_en_c;
  logic                  xfer_c;
  logic [DATA_WIDTH-1:0] s_data_a [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign s_data_a[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign any_valid_c = |s_tvalid;
  assign load_en_c   = !m_tvalid_q || m_tready;
  assign xfer_c      = load_en_c && any_valid_c;

  // Owner keeps the grant until its allowance is spent; otherwise scan from owner+1, owner last
  always_comb begin
    logic             found;
    logic [SRC_W-1:0] cand;
    sel_c = owner_q;
    found = 1'b0;
    cand  = owner_q;
    if (s_tvalid[owner_q] && (burst_cnt_q != BURST_MAX)) begin
      found = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        cand = SRC_W'((32'(owner_q) + k) % NUM_PORTS);
        if (!found && s_tvalid[cand]) begin
          sel_c = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (rst_n && xfer_c) s_tready[sel_c] = 1'b1;
  end

  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tsrc_d    = m_tsrc_q;
    if (xfer_c) begin
      m_tdata_d  = s_data_a[sel_c];
      m_tsrc_d   = sel_c;
      m_tvalid_d = 1'b1;
      // New owner, or sole requester re-selected after exhausting its allowance
      if ((sel_c != owner_q) || (burst_cnt_q == BURST_MAX)) begin
        owner_d     = sel_c;
        burst_cnt_d = CNT_W'(1);
      end else begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
    end else if (load_en_c) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= '0;
      burst_cnt_q <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tsrc_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tsrc_q    <= m_tsrc_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tsrc   = m_tsrc_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: a queue-based reference model predicts every
// accepted beat; a separate monitor pops and compares whenever the DUT emits one.
module tb_axis_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int MB = 2;
  localparam int M_ALL  = 0;
  localparam int M_RAND = 1;
  localparam int M_MAN  = 2;

  typedef struct {
    int          src;
    logic [15:0] data;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]   s_tvalid;
  logic [NP-1:0]   s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [1:0]      m_tsrc;

  logic [NP-1:0]   s_tready1;
  logic [DW-1:0]   m_tdata1;
  logic            m_tvalid1;
  logic [1:0]      m_tsrc1;

  int vectors = 0;
  int miscompares = 0;

  int          mode = M_ALL;
  logic [NP-1:0] man_valid = '0;
  logic        man_ready = 1'b1;
  logic [15:0] seq [NP];
  logic [NP-1:0] hs;

  beat_t       exp_q[$];
  int          mdl_owner, mdl_cnt, g, exp1;
  bit          mdl_valid, ld;
  logic [NP-1:0] er;

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tsrc(m_tsrc));

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(1)) u_rr1 (
    .clk(clk), .rst_n(rst_n), .s_tdata({16'h0333, 16'h0222, 16'h0111, 16'h0000}),
    .s_tvalid(4'hF), .s_tready(s_tready1),
    .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(1'b1), .m_tsrc(m_tsrc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Fairness rule: owner continues while it has allowance, else next requester after it
  function automatic int pick(input logic [NP-1:0] v);
    if (v[mdl_owner] && mdl_cnt < MB) return mdl_owner;
    for (int k = 1; k <= NP; k++)
      if (v[(mdl_owner + k) % NP]) return (mdl_owner + k) % NP;
    return -1;
  endfunction

  // Source driver: holds each port's beat until accepted, then advances its sequence
  always @(posedge clk) begin
    logic [NP-1:0] want;
    #1;
    for (int i = 0; i < NP; i++) begin
      if (!rst_n) seq[i] = 16'h0;
      else if (hs[i]) seq[i] = seq[i] + 16'h1;
    end
    case (mode)
      M_ALL:   begin want = 4'hF; m_tready = 1'b1; end
      M_RAND:  begin want = 4'($urandom); m_tready = ($urandom_range(0, 3) != 0); end
      default: begin want = man_valid; m_tready = man_ready; end
    endcase
    s_tvalid = want;
    for (int i = 0; i < NP; i++)
      s_tdata[i*DW +: DW] = (i == 2) ? 16'(16'hA0 + seq[i]) : 16'(i * 4096 + int'(seq[i]));
  end

  // Reference model: predicts the handshake at the coming edge and queues the beat
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_owner = 0; mdl_cnt = 0; mdl_valid = 0; hs = '0;
      exp_q.delete();
    end else begin
      ld = !mdl_valid || m_tready;
      g  = ld ? pick(s_tvalid) : -1;
      er = (g >= 0) ? 4'(1 << g) : 4'h0;
      chk("s_tready", 64'(s_tready), 64'(er));
      chk("m_tvalid", 64'(m_tvalid), 64'(mdl_valid));
      hs = s_tvalid & s_tready;
      if (g >= 0) begin
        exp_q.push_back('{src: g, data: s_tdata[g*DW +: DW]});
        if (g != mdl_owner) begin mdl_owner = g; mdl_cnt = 1; end
        else if (mdl_cnt == MB) mdl_cnt = 1;
        else mdl_cnt = mdl_cnt + 1;
        mdl_valid = 1;
      end else if (ld) begin
        mdl_valid = 0;
      end
    end
  end

  // Monitor: every consumed output beat must match the oldest predicted beat
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp1 = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL beat: got src %0d data %0h expected no beat", m_tsrc, m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("m_tsrc", 64'(m_tsrc), 64'(e.src));
          chk("m_tdata", 64'(m_tdata), 64'(e.data));
        end
      end
      if (m_tvalid1) begin
        chk("mb1_tsrc", 64'(m_tsrc1), 64'(exp1));
        exp1 = (exp1 + 1) % NP;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'(0));
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({tag, "_m_tdata"},  64'(m_tdata),  64'(0));
    chk({tag, "_m_tsrc"},   64'(m_tsrc),   64'(0));
  endtask

  // Reset asserted between edges; released just after a rising edge
  task automatic do_reset(input string tag);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_reset_state(tag);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_tvalid = '0; s_tdata = '0; m_tready = 1'b1; hs = '0;
    for (int i = 0; i < NP; i++) seq[i] = 16'h0;

    // Reset with all sources requesting, then full contention
    mode = M_ALL;
    do_reset("rst1");
    repeat (12) @(negedge clk);

    // Port 2 owns a burst when reset hits mid-stream
    mode = M_MAN; man_valid = 4'b0100; man_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_m_tvalid", 64'(m_tvalid), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mid");
    mode = M_ALL;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single source: port 2 streams 0xA0..0xA4
    mode = M_MAN; man_valid = 4'b0000;
    do_reset("rst3");
    @(negedge clk); man_valid = 4'b0100;
    repeat (5) @(negedge clk); man_valid = 4'b0000;
    repeat (3) @(negedge clk);

    // Owner drop: port 1 one beat, then port 3 takes over, then both contend
    man_valid = 4'b0010; @(negedge clk);
    man_valid = 4'b1000; @(negedge clk);
    man_valid = 4'b1010; repeat (6) @(negedge clk);

    // Backpressure for 3 cycles under full contention
    man_valid = 4'b1111; repeat (4) @(negedge clk);
    man_ready = 1'b0;    repeat (3) @(negedge clk);
    man_ready = 1'b1;    repeat (4) @(negedge clk);

    // Random traffic and backpressure
    mode = M_RAND;
    repeat (3000) @(negedge clk);

    // Drain: nothing predicted may remain unconsumed
    mode = M_MAN; man_valid = 4'b0000; man_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain_queue", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Shares one AXI-Stream sink among NUM_PORTS AXI-Stream sources (e.g. per-channel encoder sample streams merged onto one upstream link). Arbitration is round-robin with a configurable burst allowance: the current owner may send up to MAX_BURST consecutive beats before lower-ranked requesters get priority. The output is fully registered, and each output beat carries the index of the source that produced it.

## Interface
- NUM_PORTS, 4: number of source streams, ≥2.
- DATA_WIDTH, 64: tdata width of every stream.
- MAX_BURST, 4: maximum consecutive beats granted to one owner while others wait, ≥1.
- SRC_W, $clog2(NUM_PORTS): width of m_tsrc (derived, not overridden).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  source data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_PORTS  source valid, bit i = port i.
- s_tready  out  NUM_PORTS  source ready, at most one bit high (one-hot or zero).
- m_tdata  out  DATA_WIDTH  merged data.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  sink ready.
- m_tsrc  out  SRC_W  source index of current m_tdata beat.

## Operation
- State: owner (SRC_W, reset 0) and burst_cnt (0..MAX_BURST, reset 0), plus output register m_tdata/m_tvalid/m_tsrc.
- load_en = !m_tvalid || m_tready.
- Selection (combinational, each cycle):
  - If s_tvalid[owner] and burst_cnt != MAX_BURST: sel = owner.
  - Otherwise: sel = first valid port scanning owner+1, owner+2, … modulo NUM_PORTS. The owner itself is scanned last.
  - any_valid = |s_tvalid.
- s_tready[i] = rst_n && load_en && any_valid && (i == sel). Ready may depend on valid. Valid never depends on ready.
- Transfer on s_tvalid[sel] && s_tready[sel]:
  - Load m_tdata <= s_tdata[sel], m_tsrc <= sel, m_tvalid <= 1.
  - If sel != owner: owner <= sel, burst_cnt <= 1.
  - If sel == owner and burst_cnt == MAX_BURST (sole requester re-selected): burst_cnt <= 1.
  - Else: burst_cnt <= burst_cnt + 1.
- If load_en && !any_valid: m_tvalid <= 0. m_tdata and m_tsrc hold their last values. owner and burst_cnt hold.
- If owner drops s_tvalid mid-burst, the grant rotates in the same cycle with no idle cycle.
- MAX_BURST=1 gives pure per-beat round robin.
- Reset (rst_n low, asynchronous): m_tvalid=0, m_tdata=0, m_tsrc=0, owner=0, burst_cnt=0, all s_tready=0. Any registered beat is discarded. First grant after reset prefers port 0, then 1, 2, ….

## Timing
- Latency: source handshake in cycle N → beat on m_tdata/m_tvalid from cycle N+1.
- Throughput: 1 beat/cycle with m_tready held high; no bubbles between owners.
- Backpressure: while m_tvalid && !m_tready, m_tdata, m_tsrc and m_tvalid are stable and all s_tready=0.
- Simultaneous m_tready and new transfer: the output beat is consumed and replaced in the same edge.
- Fairness bound: a continuously valid port waits at most (NUM_PORTS−1)*MAX_BURST accepted beats.
- Combinational paths: s_tvalid → s_tready and m_tready → s_tready only. No combinational path to any m_* output.

## Test plan
Parameters: NUM_PORTS=4, DATA_WIDTH=16, MAX_BURST=2 unless stated.
- Reset: hold rst_n=0 with s_tvalid=4'hF, m_tready=1 → s_tready=0, m_tvalid=0, m_tdata=0, m_tsrc=0. First output after release has m_tsrc=0.
- Single source: port 2 streams 0xA0..0xA4 back-to-back, m_tready=1 → m_tdata 0xA0..0xA4 on consecutive cycles starting one cycle after first accept, m_tsrc=2 throughout, no gaps.
- Full contention: all ports continuously valid, m_tready=1 → m_tsrc sequence 0,0,1,1,2,2,3,3,0,0. Repeat with MAX_BURST=1 → 0,1,2,3,0.
- Backpressure: with m_tvalid=1, drop m_tready for 3 cycles → m_tdata/m_tsrc unchanged and s_tready=0 for all 3 cycles. On release, the next beat appears the following cycle with no beat lost or duplicated.
- Owner drop: port 1 sends one beat (burst_cnt=1), then deasserts while port 3 is valid → next beat has m_tsrc=3 with no idle cycle. Port 3 then gets 2 beats before port 1 (re-asserted) is served.
- Reset mid-stream: assert rst_n=0 while m_tvalid=1 and port 2 owns a burst → m_tvalid falls without waiting for clk. After release with all ports valid, the order restarts 0,0,1,1.
